// File: rtl/us_pkg.sv
// Shared types and width helpers for the ultrasound burst array.
package us_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } us_state_t;

    localparam int BURST_CNT_W = 16;

    // Bits needed to hold the values 0 .. n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/us_ch_pulser.sv
// One transmit channel: emits PULSES square-wave cycles after a start pulse.
// With ULTRASOUND_DEADTIME_EN defined, also drives a dead-time-separated vin_n.
module us_ch_pulser
    import us_pkg::*;
#(
    parameter int HALF_CNT = 277,
    parameter int PULSES   = 10
`ifdef ULTRASOUND_DEADTIME_EN
    ,
    parameter int DEAD_CNT = 10
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic vin,
`ifdef ULTRASOUND_DEADTIME_EN
    output logic vin_n,
`endif
    output logic done
);

    localparam int HC_W  = cnt_w(HALF_CNT + 1);
    localparam int IDX_W = cnt_w(2 * PULSES);
    localparam logic [HC_W-1:0]  HC_MAX   = HC_W'(HALF_CNT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * PULSES - 1);

    logic             act;
    logic             ph;
    logic [HC_W-1:0]  hc;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act  <= 1'b0;
            ph   <= 1'b0;
            hc   <= '0;
            idx  <= '0;
            done <= 1'b0;
        end else if (abort) begin
            act  <= 1'b0;
            ph   <= 1'b0;
            hc   <= '0;
            idx  <= '0;
            done <= 1'b0;
        end else if (start) begin
            act  <= 1'b1;
            ph   <= 1'b1;
            hc   <= '0;
            idx  <= '0;
            done <= 1'b0;
        end else if (act) begin
            if (hc == HC_MAX) begin
                hc <= '0;
                if (idx == IDX_LAST) begin
                    act  <= 1'b0;
                    ph   <= 1'b0;
                    done <= 1'b1;
                end else begin
                    ph  <= ~ph;
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                hc <= hc + HC_W'(1);
            end
        end
    end

`ifdef ULTRASOUND_DEADTIME_EN
    localparam int D_W = cnt_w(DEAD_CNT + 1);

    logic [1:0]     want;
    logic [1:0]     want_q;
    logic [D_W-1:0] dcnt;
    logic           blank;

    // Blanking starts in the cycle the wanted pair changes, so falling edges are immediate.
    assign want  = {act & ~ph, ph};
    assign blank = (want != want_q) || (dcnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            want_q <= 2'b00;
            dcnt   <= '0;
        end else begin
            want_q <= want;
            if (want != want_q)
                dcnt <= D_W'(DEAD_CNT - 1);
            else if (dcnt != '0)
                dcnt <= dcnt - D_W'(1);
        end
    end

    assign vin   = want[0] & ~blank;
    assign vin_n = want[1] & ~blank;
`else
    assign vin = ph;
`endif

endmodule

// File: rtl/ultrasound_burst_array.sv
// N-channel ultrasound burst generator with per-channel start delay and auto-repeat.
// Optional ULTRASOUND_DEADTIME_EN adds complementary vin_n outputs with dead time.
module ultrasound_burst_array
    import us_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int HALF_CNT = 277,
    parameter int PULSES   = 10,
    parameter int PRF_CNT  = 499_999,
    parameter int DLY_W    = 8
`ifdef ULTRASOUND_DEADTIME_EN
    ,
    parameter int DEAD_CNT = 10
`endif
) (
    input  logic                    clk_50M,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    trig,
    input  logic [N_CH*DLY_W-1:0]   delay_in,
    output logic [N_CH-1:0]         vin,
    output logic                    busy,
    output logic                    burst_done,
    output logic [BURST_CNT_W-1:0]  burst_cnt
`ifdef ULTRASOUND_DEADTIME_EN
    ,
    output logic [N_CH-1:0]         vin_n
`endif
);

    localparam int T_W = DLY_W + 1;
    localparam int P_W = cnt_w(PRF_CNT + 1);
    localparam logic [T_W-1:0] T_MAX = '1;
    localparam logic [P_W-1:0] P_MAX = P_W'(PRF_CNT);

    us_state_t             state;
    logic [T_W-1:0]        t;
    logic [P_W-1:0]        p;
    logic [N_CH*DLY_W-1:0] dly_q;
    logic [N_CH-1:0]       start_v;
    logic [N_CH-1:0]       done_v;
    logic                  abort;

    // Handshake: busy is high in FIRE and HOLD; burst_done is a single-cycle pulse on the
    // first HOLD cycle, the same cycle burst_cnt shows the new count. Requests seen while busy are dropped.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            t          <= '0;
            p          <= '0;
            dly_q      <= '0;
            burst_done <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    t <= '0;
                    p <= '0;
                    if (trig | en) begin
                        state <= FIRE;
                        dly_q <= delay_in;
                    end
                end
                FIRE: begin
                    if (t != T_MAX) t <= t + T_W'(1);
                    if (p != P_MAX) p <= p + P_W'(1);
                    if (&done_v) begin
                        state      <= HOLD;
                        burst_done <= 1'b1;
                        burst_cnt  <= burst_cnt + BURST_CNT_W'(1);
                    end
                end
                HOLD: begin
                    t <= '0;
                    if (p == P_MAX) begin
                        p     <= '0;
                        state <= en ? FIRE : IDLE;
                    end else begin
                        p <= p + P_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign abort = (state != FIRE);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign start_v[i] = (state == FIRE) && (t == T_W'(dly_q[i*DLY_W +: DLY_W]));

        us_ch_pulser #(
            .HALF_CNT (HALF_CNT),
            .PULSES   (PULSES)
`ifdef ULTRASOUND_DEADTIME_EN
            ,
            .DEAD_CNT (DEAD_CNT)
`endif
        ) u_ch (
            .clk   (clk_50M),
            .rst_n (rst_n),
            .start (start_v[i]),
            .abort (abort),
            .vin   (vin[i]),
`ifdef ULTRASOUND_DEADTIME_EN
            .vin_n (vin_n[i]),
`endif
            .done  (done_v[i])
        );
    end

endmodule

// File: doc/ultrasound_burst_array.md
Name: ultrasound_burst_array

Overview:
- Parametrised N-channel ultrasound transmit burst generator; successor to the fixed 4-channel 90 kHz / 10 ms launcher.
- Adds:
  - per-channel programmable start delay, for beam steering;
  - configurable burst length;
  - single-shot or auto-repeat mode;
  - a busy/done handshake.
- Sits between the system controller and the transducer drivers. The LED heartbeat remains a separate block.

Parameters:
N_CH, 4, number of transmit channels (1..16)
HALF_CNT, 277, toggle interval minus 1 in clk_50M cycles (278 cycles → ≈89.9 kHz square wave)
PULSES, 10, full carrier cycles per burst per channel (≥1)
PRF_CNT, 499_999, repetition interval minus 1 in clk_50M cycles (10 ms)
DLY_W, 8, width of each channel delay field (cycles)

Ports:
clk_50M  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
en  in  1  auto-repeat enable
trig  in  1  single-burst request, level-sampled in IDLE
delay_in  in  N_CH*DLY_W  per-channel start delay; channel i uses bits [i*DLY_W +: DLY_W]
vin  out  N_CH  transducer drive, idle low
busy  out  1  high outside IDLE
burst_done  out  1  one-cycle pulse when all channels finish a burst
burst_cnt  out  16  count of completed bursts since reset; wraps 0xFFFF→0

Behaviour:
- Reset (async, rst_n=0):
  - Clears all state and counters.
  - vin=0, busy=0, burst_done=0, burst_cnt=0.
  - Takes effect immediately, including mid-burst.
- FSM states:
  - IDLE: all counters held at 0.
  - FIRE: global tick counter t runs and channels pulse. The period counter p starts at 0 on entry.
  - HOLD: all channels done; waiting for p==PRF_CNT.
- Transitions:
  - IDLE→FIRE when (trig | en) is sampled high. On the same edge, delay_in is latched into an internal register; later delay_in changes do not affect the running burst.
  - FIRE→HOLD on the edge after all channels report done. burst_done pulses for that one cycle and burst_cnt increments.
  - HOLD→FIRE when p==PRF_CNT and en=1. p resets to 0 on this transition.
  - HOLD→IDLE when p==PRF_CNT and en=0.
- Period counter p:
  - Saturates at PRF_CNT.
  - If FIRE lasts longer than PRF_CNT, HOLD lasts exactly 1 cycle and the next burst follows immediately. The period stretches; no burst is truncated.
- Channel timing (delay d):
  - Channel start edge is the edge where t==d in FIRE.
  - vin[i] is registered high from the following cycle.
  - vin[i] toggles every HALF_CNT+1 cycles, for 2*PULSES half-periods.
  - It then holds low and asserts done.
  - First rising edge of vin[i] = d+1 cycles after the edge that samples trig/en.
- Pulse shape: high time = low time = HALF_CNT+1 cycles; each burst has exactly PULSES rising edges per channel.
- Delay d=0: channel starts on the first FIRE cycle. Equal delays give identical waveforms.
- t width: DLY_W+1 bits, saturating at max.
- trig while busy: ignored; no queueing.
- en deasserted mid-FIRE: current burst completes, HOLD runs out the period, then the FSM goes to IDLE.
- trig=1 held in IDLE with en=0: bursts repeat at the PRF interval for as long as trig is held.

Optional Feature:
ULTRASOUND_DEADTIME_EN:
- Defined:
  - Adds output vin_n [N_CH], the complement of vin for an H-bridge drive.
  - Adds parameter DEAD_CNT (default 10).
  - At every vin transition, both vin[i] and vin_n[i] are low for DEAD_CNT cycles. The rising output is delayed by DEAD_CNT cycles and the falling output switches immediately.
  - Outside a burst vin_n=0.
  - Pulse period is unchanged.
  - Reset value 0.
- Undefined: no vin_n port, no dead-time logic.

Decomposition:
- Package us_pkg:
  - FSM state enum (IDLE, FIRE, HOLD);
  - localparam functions for counter widths ($clog2 of HALF_CNT+1, PULSES*2, PRF_CNT+1);
  - BURST_CNT_W=16.
- Sub-module us_ch_pulser, instantiated N_CH times:
  - Inputs: start pulse, abort.
  - Contains its own half-period counter, half-period index counter and output register.
  - Outputs: vin bit, done. Optional vin_n with dead time.
- Top level holds the FSM, t, p, the delay register and burst_cnt.

Test Plan (HALF_CNT=3, PULSES=2, PRF_CNT=99, N_CH=4, DLY_W=8 unless noted):
- Single shot: en=0, delays all 0, 1-cycle trig at cycle 10 → each vin high cycles 12–15 and 20–23, low otherwise; burst_done pulses once; burst_cnt=1; busy falls 100 cycles after FIRE entry.
- Steering: delays {0,5,10,20}, trig → vin[i] first rise offset by exactly 0/5/10/20 cycles relative to vin[0]; each channel has 2 pulses; burst_done follows vin[3]'s last fall.
- Auto-repeat: en=1 for 350 cycles, then 0 → bursts start at period spacing 100 cycles; the burst in progress when en falls completes; final burst_cnt=4; then IDLE.
- Overlong burst: PRF_CNT=9, PULSES=4 → HOLD lasts 1 cycle; next FIRE starts immediately; no pulse truncated.
- Mid-burst reset: rst_n low during a vin high phase → vin, busy and burst_cnt go 0 asynchronously; after release, IDLE with no spurious pulses; trig while busy is ignored (burst count unchanged).
- ULTRASOUND_DEADTIME_EN, DEAD_CNT=1 → vin & vin_n are never both high; each transition has a 1-cycle both-low gap.
